// File: rtl/synth_mul_pkg.sv
// Shared definitions for the sequential Q-format multiplier.
// State encoding and step/count sizing helpers.
package synth_mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Number of CALC cycles for a given width and radix
    function automatic int calc_steps(input int w, input int s);
        return w / s;
    endfunction

    // Counter width able to hold 0..N
    function automatic int cnt_width(input int w, input int s);
        return $clog2(w / s + 1);
    endfunction

endpackage

// File: rtl/mul_round_sat.sv
// Rounds the exact product to Q-format and clamps it to the
// signed or unsigned output range.
module mul_round_sat #(
    parameter int C_WIDTH = 8,
    parameter int C_FRAC  = 0
) (
    input  logic [2*C_WIDTH-1:0] i_full,
    input  logic                 i_signed,
    output logic [C_WIDTH-1:0]   o_y,
    output logic                 o_ovf
);

    // Two guard bits so the rounding add never wraps
    localparam int EW = 2 * C_WIDTH + 2;

    localparam logic signed [EW-1:0] C_HALF =
        (EW'(1) << C_FRAC) >> 1;
    localparam logic signed [EW-1:0] C_UMAX =
        {{(EW-C_WIDTH){1'b0}}, {C_WIDTH{1'b1}}};
    localparam logic signed [EW-1:0] C_SMAX =
        {{(EW-C_WIDTH+1){1'b0}}, {(C_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] C_SMIN =
        {{(EW-C_WIDTH+1){1'b1}}, {(C_WIDTH-1){1'b0}}};

    logic signed [EW-1:0] w_ext;
    logic signed [EW-1:0] w_rnd;
    logic signed [EW-1:0] w_shr;
    logic signed [EW-1:0] w_hi;
    logic signed [EW-1:0] w_lo;

    // Extend, round half up, then arithmetic shift (unsigned stays positive)
    always_comb begin
        w_ext = i_signed ? {{2{i_full[2*C_WIDTH-1]}}, i_full}
                         : {2'b00, i_full};
        w_rnd = w_ext + C_HALF;
        w_shr = w_rnd >>> C_FRAC;
        w_hi  = i_signed ? C_SMAX : C_UMAX;
        w_lo  = i_signed ? C_SMIN : '0;
    end

    // Clamp to the output range and flag when the clamp acted
    always_comb begin
        o_y   = w_shr[C_WIDTH-1:0];
        o_ovf = 1'b0;
        if (w_shr > w_hi) begin
            o_y   = w_hi[C_WIDTH-1:0];
            o_ovf = 1'b1;
        end else if (w_shr < w_lo) begin
            o_y   = w_lo[C_WIDTH-1:0];
            o_ovf = 1'b1;
        end
    end

endmodule

// File: rtl/seq_multiplier_q.sv
// Multi-cycle shift-add multiplier with radix C_STEP, signed mode,
// full-precision product and rounded/saturated Q-format output.
module seq_multiplier_q #(
    parameter int C_WIDTH = 8,
    parameter int C_FRAC  = 0,
    parameter int C_STEP  = 1
) (
    input  logic                 ctl_clk,
    input  logic                 reset,
    input  logic                 trigger,
    input  logic                 is_signed,
    input  logic [C_WIDTH-1:0]   a,
    input  logic [C_WIDTH-1:0]   b,
    output logic                 ready,
    output logic                 done,
    output logic [C_WIDTH-1:0]   y,
    output logic [2*C_WIDTH-1:0] y_full,
    output logic                 ovf
);

    import synth_mul_pkg::*;

    localparam int N  = calc_steps(C_WIDTH, C_STEP);
    localparam int CW = cnt_width(C_WIDTH, C_STEP);
    localparam int W2 = 2 * C_WIDTH;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [W2-1:0]       r_acc;
    logic [W2-1:0]       r_mcand;
    logic [C_WIDTH-1:0]  r_mplier;
    logic                r_neg;
    logic                r_sgn;
    logic                r_ready;
    logic                r_done;
    logic [C_WIDTH-1:0]  r_y;
    logic [W2-1:0]       r_full;
    logic                r_ovf;

    logic [C_WIDTH-1:0]  w_mag_a;
    logic [C_WIDTH-1:0]  w_mag_b;
    logic [W2-1:0]       w_pp;
    logic [W2-1:0]       w_fix_full;
    logic [C_WIDTH-1:0]  w_y;
    logic                w_ovf;
    logic                w_accept;
    logic                w_last;

    // Operand magnitudes; -2^(W-1) maps exactly to 2^(W-1) unsigned
    always_comb begin
        w_mag_a = (is_signed && a[C_WIDTH-1]) ? (~a + 1'b1) : a;
        w_mag_b = (is_signed && b[C_WIDTH-1]) ? (~b + 1'b1) : b;
    end

    // Partial product of the next C_STEP multiplier bits
    always_comb begin
        w_pp = '0;
        for (int j = 0; j < C_STEP; j++) begin
            if (r_mplier[j]) begin
                w_pp = w_pp + (r_mcand << j);
            end
        end
    end

    // Sign fix-up of the finished magnitude product
    always_comb begin
        w_fix_full = r_neg ? (~r_acc + 1'b1) : r_acc;
        w_accept   = r_ready & trigger;
        w_last     = (r_cnt == CW'(N - 1));
    end

    mul_round_sat #(
        .C_WIDTH (C_WIDTH),
        .C_FRAC  (C_FRAC)
    ) u_round_sat (
        .i_full   (w_fix_full),
        .i_signed (r_sgn),
        .o_y      (w_y),
        .o_ovf    (w_ovf)
    );

    // Control FSM, accumulator and registered outputs
    always_ff @(posedge ctl_clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_sgn    <= 1'b0;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_y      <= '0;
            r_full   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_acc    <= '0;
                        r_mcand  <= {{C_WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_neg    <= is_signed & (a[C_WIDTH-1] ^ b[C_WIDTH-1]);
                        r_sgn    <= is_signed;
                        r_cnt    <= '0;
                        r_ready  <= 1'b0;
                        r_state  <= S_CALC;
                    end else begin
                        r_ready  <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_acc    <= r_acc + w_pp;
                    r_mcand  <= r_mcand << C_STEP;
                    r_mplier <= r_mplier >> C_STEP;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_full  <= w_fix_full;
                    r_y     <= w_y;
                    r_ovf   <= w_ovf;
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= S_DONE;
                end
            endcase
        end
    end

    assign ready  = r_ready;
    assign done   = r_done;
    assign y      = r_y;
    assign y_full = r_full;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_seq_multiplier_q.sv
// Directed self-checking bench for seq_multiplier_q.
// Three instances: default, Q7 radix-2, Q7 radix-16.
module tb_seq_multiplier_q;

    logic       clk;
    logic       rst;
    logic       trg0, trg1, trg2;
    logic       sgn;
    logic [7:0] a, b;

    logic        ready0, done0, ovf0;
    logic [7:0]  y0;
    logic [15:0] f0;
    logic        ready1, done1, ovf1;
    logic [7:0]  y1;
    logic [15:0] f1;
    logic        ready2, done2, ovf2;
    logic [7:0]  y2;
    logic [15:0] f2;

    int checks = 0;
    int passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seq_multiplier_q #(.C_WIDTH(8), .C_FRAC(0), .C_STEP(1)) u0 (
        .ctl_clk(clk), .reset(rst), .trigger(trg0), .is_signed(sgn),
        .a(a), .b(b), .ready(ready0), .done(done0), .y(y0),
        .y_full(f0), .ovf(ovf0)
    );

    seq_multiplier_q #(.C_WIDTH(8), .C_FRAC(7), .C_STEP(1)) u1 (
        .ctl_clk(clk), .reset(rst), .trigger(trg1), .is_signed(sgn),
        .a(a), .b(b), .ready(ready1), .done(done1), .y(y1),
        .y_full(f1), .ovf(ovf1)
    );

    seq_multiplier_q #(.C_WIDTH(8), .C_FRAC(7), .C_STEP(4)) u2 (
        .ctl_clk(clk), .reset(rst), .trigger(trg2), .is_signed(sgn),
        .a(a), .b(b), .ready(ready2), .done(done2), .y(y2),
        .y_full(f2), .ovf(ovf2)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic run_op(input int which, input logic sg,
                          input logic [7:0] av, input logic [7:0] bv,
                          output int lat, output logic [7:0] oy,
                          output logic [15:0] of, output logic oo);
        logic d;
        sgn = sg;
        a   = av;
        b   = bv;
        case (which)
            0:       trg0 = 1'b1;
            1:       trg1 = 1'b1;
            default: trg2 = 1'b1;
        endcase
        @(posedge clk); #1;
        trg0 = 1'b0;
        trg1 = 1'b0;
        trg2 = 1'b0;
        a    = 8'hAA;
        b    = 8'h55;
        lat  = 99;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            d = (which == 0) ? done0 : (which == 1) ? done1 : done2;
            if (d) begin
                lat = i;
                break;
            end
        end
        oy = (which == 0) ? y0 : (which == 1) ? y1 : y2;
        of = (which == 0) ? f0 : (which == 1) ? f1 : f2;
        oo = (which == 0) ? ovf0 : (which == 1) ? ovf1 : ovf2;
    endtask

    initial begin
        int          lat;
        logic [7:0]  oy;
        logic [15:0] of;
        logic        oo;
        int          dcnt, first, second;

        rst  = 1'b0;
        trg0 = 1'b0;
        trg1 = 1'b0;
        trg2 = 1'b0;
        sgn  = 1'b0;
        a    = 8'h00;
        b    = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {15'd0, ready0}, 16'd0);
        chk("rst_done",  {15'd0, done0},  16'd0);
        chk("rst_y",     {8'd0, y0},      16'd0);
        chk("rst_yfull", f0,              16'd0);
        chk("rst_ovf",   {15'd0, ovf0},   16'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ready_rise", {15'd0, ready0}, 16'd1);

        // 1. unsigned 12*6
        run_op(0, 1'b0, 8'h0C, 8'h06, lat, oy, of, oo);
        chk("t1_lat",   16'(lat),      16'd9);
        chk("t1_yfull", of,            16'h0048);
        chk("t1_y",     {8'd0, oy},    16'h0048);
        chk("t1_ovf",   {15'd0, oo},   16'd0);
        chk("t1_ready_at_done", {15'd0, ready0}, 16'd1);
        @(posedge clk); #1;
        chk("t1_done_pulse", {15'd0, done0}, 16'd0);
        chk("t1_hold_y",     {8'd0, y0},     16'h0048);

        // 2. unsigned saturation, signed negative
        run_op(0, 1'b0, 8'h0D, 8'h17, lat, oy, of, oo);
        chk("t2a_yfull", of,          16'h012B);
        chk("t2a_y",     {8'd0, oy},  16'h00FF);
        chk("t2a_ovf",   {15'd0, oo}, 16'd1);
        run_op(0, 1'b1, 8'hFD, 8'h05, lat, oy, of, oo);
        chk("t2b_yfull", of,          16'hFFF1);
        chk("t2b_y",     {8'd0, oy},  16'h00F1);
        chk("t2b_ovf",   {15'd0, oo}, 16'd0);

        // 3. most negative operands
        run_op(0, 1'b1, 8'h80, 8'h80, lat, oy, of, oo);
        chk("t3a_yfull", of,          16'h4000);
        chk("t3a_y",     {8'd0, oy},  16'h007F);
        chk("t3a_ovf",   {15'd0, oo}, 16'd1);
        run_op(0, 1'b1, 8'h80, 8'h7F, lat, oy, of, oo);
        chk("t3b_yfull", of,          16'hC080);
        chk("t3b_y",     {8'd0, oy},  16'h0080);
        chk("t3b_ovf",   {15'd0, oo}, 16'd1);

        // 4. Q7 rounding, radix 2 and radix 16
        run_op(1, 1'b1, 8'h40, 8'h40, lat, oy, of, oo);
        chk("t4a_lat",   16'(lat),    16'd9);
        chk("t4a_yfull", of,          16'h1000);
        chk("t4a_y",     {8'd0, oy},  16'h0020);
        chk("t4a_ovf",   {15'd0, oo}, 16'd0);
        run_op(1, 1'b1, 8'h41, 8'h41, lat, oy, of, oo);
        chk("t4b_yfull", of,          16'h1081);
        chk("t4b_y",     {8'd0, oy},  16'h0021);
        run_op(2, 1'b1, 8'h40, 8'h40, lat, oy, of, oo);
        chk("t4c_lat",   16'(lat),    16'd3);
        chk("t4c_y",     {8'd0, oy},  16'h0020);
        run_op(2, 1'b1, 8'h41, 8'h41, lat, oy, of, oo);
        chk("t4d_lat",   16'(lat),    16'd3);
        chk("t4d_yfull", of,          16'h1081);
        chk("t4d_y",     {8'd0, oy},  16'h0021);
        run_op(2, 1'b1, 8'hC0, 8'h40, lat, oy, of, oo);
        chk("t4e_yfull", of,          16'hF000);
        chk("t4e_y",     {8'd0, oy},  16'h00E0);

        // 5. trigger held for 20 cycles
        repeat (3) @(posedge clk);
        #1;
        sgn  = 1'b0;
        a    = 8'h03;
        b    = 8'h04;
        dcnt = 0;
        first = 0;
        second = 0;
        trg0 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done0) begin
                dcnt++;
                if (first == 0) first = i;
                else second = i;
            end
        end
        trg0 = 1'b0;
        chk("t5_y", {8'd0, y0}, 16'h000C);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done0) dcnt++;
        end
        chk("t5_ndone",  16'(dcnt),   16'd2);
        chk("t5_first",  16'(first),  16'd10);
        chk("t5_second", 16'(second), 16'd20);

        // 6. reset during CALC
        sgn  = 1'b0;
        a    = 8'h0D;
        b    = 8'h17;
        trg0 = 1'b1;
        @(posedge clk); #1;
        trg0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t6_ready", {15'd0, ready0}, 16'd0);
        chk("t6_done",  {15'd0, done0},  16'd0);
        chk("t6_y",     {8'd0, y0},      16'd0);
        chk("t6_yfull", f0,              16'd0);
        chk("t6_ovf",   {15'd0, ovf0},   16'd0);
        rst  = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done0) dcnt++;
        end
        chk("t6_no_done", 16'(dcnt), 16'd0);
        run_op(0, 1'b1, 8'hFD, 8'h05, lat, oy, of, oo);
        chk("t6_lat",   16'(lat),   16'd9);
        chk("t6_yfull", of,         16'hFFF1);
        chk("t6_y",     {8'd0, oy}, 16'h00F1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
